// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM update controller.
//   - pwm_state_e : controller FSM states
//   - REG_*       : host write address map (address 3 is reserved; writes are
//                   accepted and ignored)
//   - CTRL_*      : bit positions inside a control-register write
package pwm_pkg;

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_RUN      = 2'd1,
    S_PEND     = 2'd2,
    S_RAMP     = 2'd3
  } pwm_state_e;

  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_ON     = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_COMMIT = 1;

endpackage

// File: rtl/pwm_ramp_step.sv
// pwm_ramp_step: combinational clamp-and-step for the active ON time.
//   Ports:
//     act_on    - current active ON time
//     target_on - ON time being approached
//     period    - period the result must fit inside (clamp bound)
//     next_on   - ON time after clamping to period and one step toward target
//   The current value is first clamped to the period, then moved toward the
//   target by at most RAMP_STEP (RAMP_STEP == 0 jumps straight to the target).
//   All arithmetic is unsigned; a partial final step lands exactly on the
//   target, so the result never wraps or overshoots.
module pwm_ramp_step #(
  parameter int PWM_WIDTH = 32,
  parameter int RAMP_STEP = 0
) (
  input  logic [PWM_WIDTH-1:0] act_on,
  input  logic [PWM_WIDTH-1:0] target_on,
  input  logic [PWM_WIDTH-1:0] period,
  output logic [PWM_WIDTH-1:0] next_on
);

  localparam logic [PWM_WIDTH-1:0] STEP = PWM_WIDTH'(RAMP_STEP);

  logic [PWM_WIDTH-1:0] clamped;
  logic [PWM_WIDTH-1:0] diff;

  always_comb begin
    clamped = (act_on > period) ? period : act_on;
    diff    = (clamped >= target_on) ? (clamped - target_on) : (target_on - clamped);
    next_on = target_on;
    if (RAMP_STEP != 0 && diff > STEP) begin
      if (clamped > target_on) begin
        next_on = clamped - STEP;
      end else begin
        next_on = clamped + STEP;
      end
    end
  end

endmodule

// File: rtl/pwm_update_ctrl.sv
// pwm_update_ctrl: shadow/active configuration controller for one PWM channel.
//   Ports:
//     clk, reset             - clock, asynchronous active-low reset
//     wr_valid/wr_ready      - host write handshake
//     wr_addr, wr_data       - 0=period, 1=ON time, 2=control (bit0 enable,
//                              bit1 commit), 3=reserved
//     stop                   - single-cycle pulse forcing the channel disabled
//     period_end             - end-of-period pulse from the period counter
//     pwm_enable             - run request to the PWM FSM
//     T_period_value/T_on_value - active values the FSM reloads from
//     T_on_MAX / T_on_MIN    - registered ON==period / ON==0 qualifiers
//     busy                   - update pending or ramp in progress
//
// Handshake: a write transfers on any rising edge where wr_valid && wr_ready.
// wr_ready depends only on state (low while an update waits for the period
// boundary), never on wr_valid, so the host may hold wr_valid indefinitely.
//
// Active values change only on a commit while disabled, on period_end while
// pending or ramping, or at reset, so the FSM always reloads stable values.
module pwm_update_ctrl
  import pwm_pkg::*;
#(
  parameter int PWM_UNIT  = 0,
  parameter int PWM_WIDTH = 32,
  parameter int RAMP_STEP = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [1:0]           wr_addr,
  input  logic [PWM_WIDTH-1:0] wr_data,
  input  logic                 stop,
  input  logic                 period_end,
  output logic                 pwm_enable,
  output logic [PWM_WIDTH-1:0] T_period_value,
  output logic [PWM_WIDTH-1:0] T_on_value,
  output logic                 T_on_MAX,
  output logic                 T_on_MIN,
  output logic                 busy
);

  // PWM_UNIT only identifies the channel; reject nonsensical values early.
  if (PWM_UNIT < 0 || RAMP_STEP < 0) begin : g_param_check
    $error("pwm_update_ctrl: PWM_UNIT and RAMP_STEP must be non-negative");
  end

  pwm_state_e state, state_d;

  logic [PWM_WIDTH-1:0] shadow_period, shadow_on;
  logic [PWM_WIDTH-1:0] act_period, act_on, target_on;
  logic [PWM_WIDTH-1:0] act_period_d, act_on_d, target_on_d;
  logic [PWM_WIDTH-1:0] shadow_target, start_on;
  logic [PWM_WIDTH-1:0] step_period, step_target, step_on;

  logic wr_fire, ctrl_wr, commit, enable_bit, commit_en, disable_wr;

  assign wr_fire    = wr_valid && wr_ready;
  assign ctrl_wr    = wr_fire && (wr_addr == REG_CTRL);
  assign enable_bit = wr_data[CTRL_ENABLE];
  assign commit     = ctrl_wr && wr_data[CTRL_COMMIT];
  assign commit_en  = commit && enable_bit;
  // Any control write with enable low stops a running channel, commit or not.
  assign disable_wr = ctrl_wr && !enable_bit;

  // ON time may never exceed the period it is paired with.
  assign shadow_target = (shadow_on > shadow_period) ? shadow_period : shadow_on;
  // Soft start begins from 0 whenever slew limiting is active.
  assign start_on = (RAMP_STEP == 0) ? shadow_target : '0;

  // While pending, the step runs against the incoming period/target; while
  // ramping, against the already active ones.
  assign step_period = (state == S_PEND) ? shadow_period : act_period;
  assign step_target = (state == S_PEND) ? shadow_target : target_on;

  pwm_ramp_step #(
    .PWM_WIDTH(PWM_WIDTH),
    .RAMP_STEP(RAMP_STEP)
  ) u_ramp_step (
    .act_on   (act_on),
    .target_on(step_target),
    .period   (step_period),
    .next_on  (step_on)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_DISABLED;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    if (stop) begin
      state_d = S_DISABLED;
    end else begin
      unique case (state)
        S_DISABLED: begin
          if (commit_en) begin
            state_d = (start_on != shadow_target) ? S_RAMP : S_RUN;
          end
        end
        S_RUN: begin
          if (disable_wr) begin
            state_d = S_DISABLED;
          end else if (commit_en) begin
            state_d = S_PEND;
          end
        end
        S_PEND: begin
          if (period_end) begin
            state_d = (step_on != shadow_target) ? S_RAMP : S_RUN;
          end
        end
        S_RAMP: begin
          // A write on the same edge as a step wins the state transition;
          // the step itself still completes against the old target.
          if (disable_wr) begin
            state_d = S_DISABLED;
          end else if (commit_en) begin
            state_d = S_PEND;
          end else if (period_end && step_on == target_on) begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_DISABLED;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    wr_ready = (state != S_PEND);
    busy     = (state == S_PEND) || (state == S_RAMP);
  end

  // Next active values
  always_comb begin
    act_period_d = act_period;
    act_on_d     = act_on;
    target_on_d  = target_on;
    if (!stop) begin
      unique case (state)
        S_DISABLED: begin
          if (commit) begin
            act_period_d = shadow_period;
            target_on_d  = shadow_target;
            act_on_d     = enable_bit ? start_on : shadow_target;
          end
        end
        S_PEND: begin
          if (period_end) begin
            act_period_d = shadow_period;
            target_on_d  = shadow_target;
            act_on_d     = step_on;
          end
        end
        S_RAMP: begin
          if (period_end) begin
            act_on_d = step_on;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shadow registers: plain host-writable storage, no side effects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_period <= '0;
      shadow_on     <= '0;
    end else if (wr_fire) begin
      if (wr_addr == REG_PERIOD) shadow_period <= wr_data;
      if (wr_addr == REG_ON)     shadow_on     <= wr_data;
    end
  end

  // Active values and qualifiers; flags come from the next values so they
  // line up with T_*_value in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_period <= '0;
      act_on     <= '0;
      target_on  <= '0;
      pwm_enable <= 1'b0;
      T_on_MAX   <= 1'b1;
      T_on_MIN   <= 1'b1;
    end else begin
      act_period <= act_period_d;
      act_on     <= act_on_d;
      target_on  <= target_on_d;
      pwm_enable <= (state_d != S_DISABLED);
      T_on_MAX   <= (act_on_d == act_period_d);
      T_on_MIN   <= (act_on_d == '0);
    end
  end

  assign T_period_value = act_period;
  assign T_on_value     = act_on;

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// tb_pwm_update_ctrl: directed bench with two controller instances,
// index 0 with RAMP_STEP=0 (immediate updates) and index 1 with
// RAMP_STEP=10 (soft start). Expected values are hand-computed constants.
module tb_pwm_update_ctrl;

  logic        clk;
  logic        reset;
  logic        wr_valid   [2];
  logic [1:0]  wr_addr    [2];
  logic [31:0] wr_data    [2];
  logic        stop       [2];
  logic        period_end [2];
  logic        wr_ready   [2];
  logic        pwm_enable [2];
  logic [31:0] t_period   [2];
  logic [31:0] t_on       [2];
  logic        t_on_max   [2];
  logic        t_on_min   [2];
  logic        busy       [2];

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pwm_update_ctrl #(.PWM_UNIT(0), .PWM_WIDTH(32), .RAMP_STEP(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .stop(stop[0]), .period_end(period_end[0]),
    .pwm_enable(pwm_enable[0]), .T_period_value(t_period[0]),
    .T_on_value(t_on[0]), .T_on_MAX(t_on_max[0]), .T_on_MIN(t_on_min[0]),
    .busy(busy[0])
  );

  pwm_update_ctrl #(.PWM_UNIT(1), .PWM_WIDTH(32), .RAMP_STEP(10)) u_dut1 (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .stop(stop[1]), .period_end(period_end[1]),
    .pwm_enable(pwm_enable[1]), .T_period_value(t_period[1]),
    .T_on_value(t_on[1]), .T_on_MAX(t_on_max[1]), .T_on_MIN(t_on_min[1]),
    .busy(busy[1])
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int d, input logic [1:0] a, input logic [31:0] v);
    int n = 0;
    wr_valid[d] = 1'b1;
    wr_addr[d]  = a;
    wr_data[d]  = v;
    while (wr_ready[d] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL write_timeout dut=%0d addr=%0d: wr_ready got=%b exp=1", d, a, wr_ready[d]);
    end
    tick();
    wr_valid[d] = 1'b0;
  endtask

  task automatic pulse_period_end(input int d);
    period_end[d] = 1'b1;
    tick();
    period_end[d] = 1'b0;
  endtask

  task automatic pulse_stop(input int d);
    stop[d] = 1'b1;
    tick();
    stop[d] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (t_period[d] !== 32'd0 || t_on[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset_values dut=%0d got=%0d/%0d exp=0/0", d, t_period[d], t_on[d]);
      end
      checks++;
      if (t_on_min[d] !== 1'b1 || t_on_max[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_flags dut=%0d min/max got=%b%b exp=11", d, t_on_min[d], t_on_max[d]);
      end
      checks++;
      if (pwm_enable[d] !== 1'b0 || wr_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut=%0d en/ready/busy got=%b%b%b exp=010",
                 d, pwm_enable[d], wr_ready[d], busy[d]);
      end
    end
  endtask

  task automatic test_enable_immediate();
    do_write(0, 2'd0, 32'd100);
    checks++;
    if (t_period[0] !== 32'd0) begin
      errors++;
      $display("FAIL shadow_only got=%0d exp=0", t_period[0]);
    end
    do_write(0, 2'd1, 32'd25);
    do_write(0, 2'd2, 32'd3);
    checks++;
    if (t_period[0] !== 32'd100 || t_on[0] !== 32'd25) begin
      errors++;
      $display("FAIL enable_values got=%0d/%0d exp=100/25", t_period[0], t_on[0]);
    end
    checks++;
    if (pwm_enable[0] !== 1'b1 || t_on_min[0] !== 1'b0 || t_on_max[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL enable_flags en/min/max/busy got=%b%b%b%b exp=1000",
               pwm_enable[0], t_on_min[0], t_on_max[0], busy[0]);
    end
  endtask

  task automatic test_update_pending();
    do_write(0, 2'd1, 32'd60);
    do_write(0, 2'd2, 32'd3);
    tick();
    tick();
    checks++;
    if (busy[0] !== 1'b1 || wr_ready[0] !== 1'b0 || t_on[0] !== 32'd25) begin
      errors++;
      $display("FAIL pend_hold busy/ready got=%b%b on=%0d exp=10 on=25", busy[0], wr_ready[0], t_on[0]);
    end
    pulse_period_end(0);
    checks++;
    if (t_on[0] !== 32'd60 || busy[0] !== 1'b0 || wr_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL pend_commit on=%0d busy/ready=%b%b exp on=60 01", t_on[0], busy[0], wr_ready[0]);
    end
    do_write(0, 2'd1, 32'd70);
    pulse_period_end(0);
    checks++;
    if (t_on[0] !== 32'd60 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL run_ignores_period_end on=%0d busy=%b exp on=60 busy=0", t_on[0], busy[0]);
    end
  endtask

  task automatic test_clamp();
    do_write(0, 2'd2, 32'd0);
    checks++;
    if (pwm_enable[0] !== 1'b0 || t_on[0] !== 32'd60 || t_period[0] !== 32'd100) begin
      errors++;
      $display("FAIL disable_retain en=%b vals=%0d/%0d exp en=0 100/60", pwm_enable[0], t_period[0], t_on[0]);
    end
    do_write(0, 2'd1, 32'd150);
    do_write(0, 2'd2, 32'd3);
    checks++;
    if (t_on[0] !== 32'd100 || t_on_max[0] !== 1'b1 || t_on_min[0] !== 1'b0 || pwm_enable[0] !== 1'b1) begin
      errors++;
      $display("FAIL clamp_on on=%0d max/min/en=%b%b%b exp on=100 101", t_on[0], t_on_max[0], t_on_min[0], pwm_enable[0]);
    end
    do_write(0, 2'd1, 32'd80);
    do_write(0, 2'd2, 32'd3);
    pulse_period_end(0);
    checks++;
    if (t_on[0] !== 32'd80 || t_on_max[0] !== 1'b0) begin
      errors++;
      $display("FAIL run_at_80 on=%0d max=%b exp on=80 max=0", t_on[0], t_on_max[0]);
    end
    do_write(0, 2'd0, 32'd50);
    do_write(0, 2'd2, 32'd3);
    pulse_period_end(0);
    checks++;
    if (t_period[0] !== 32'd50 || t_on[0] !== 32'd50 || t_on_max[0] !== 1'b1) begin
      errors++;
      $display("FAIL clamp_period vals=%0d/%0d max=%b exp 50/50 max=1", t_period[0], t_on[0], t_on_max[0]);
    end
  endtask

  task automatic test_commit_disabled();
    do_write(0, 2'd2, 32'd0);
    do_write(0, 2'd0, 32'd200);
    do_write(0, 2'd1, 32'd20);
    do_write(0, 2'd2, 32'd2);
    checks++;
    if (t_period[0] !== 32'd200 || t_on[0] !== 32'd20 || pwm_enable[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL commit_disabled vals=%0d/%0d en/busy=%b%b exp 200/20 00",
               t_period[0], t_on[0], pwm_enable[0], busy[0]);
    end
    do_write(0, 2'd1, 32'd30);
    do_write(0, 2'd2, 32'd1);
    checks++;
    if (t_on[0] !== 32'd20 || pwm_enable[0] !== 1'b0) begin
      errors++;
      $display("FAIL enable_no_commit on=%0d en=%b exp on=20 en=0", t_on[0], pwm_enable[0]);
    end
  endtask

  task automatic test_soft_start();
    logic [31:0] exp_steps [4];
    exp_steps[0] = 32'd10;
    exp_steps[1] = 32'd20;
    exp_steps[2] = 32'd30;
    exp_steps[3] = 32'd35;
    do_write(1, 2'd0, 32'd100);
    do_write(1, 2'd1, 32'd35);
    do_write(1, 2'd2, 32'd3);
    checks++;
    if (t_on[1] !== 32'd0 || t_period[1] !== 32'd100 || pwm_enable[1] !== 1'b1 || t_on_min[1] !== 1'b1
        || busy[1] !== 1'b1 || wr_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL soft_start_begin vals=%0d/%0d en/min/busy/ready=%b%b%b%b exp 100/0 1111",
               t_period[1], t_on[1], pwm_enable[1], t_on_min[1], busy[1], wr_ready[1]);
    end
    for (int i = 0; i < 4; i++) begin
      pulse_period_end(1);
      checks++;
      if (t_on[1] !== exp_steps[i] || busy[1] !== (i < 3) || t_on_min[1] !== 1'b0) begin
        errors++;
        $display("FAIL soft_start_step%0d on=%0d busy=%b min=%b exp on=%0d busy=%b min=0",
                 i, t_on[1], busy[1], t_on_min[1], exp_steps[i], (i < 3));
      end
    end
  endtask

  task automatic test_stop_in_pend();
    do_write(1, 2'd1, 32'd90);
    do_write(1, 2'd2, 32'd3);
    checks++;
    if (busy[1] !== 1'b1 || wr_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL stop_pre_pend busy/ready=%b%b exp=10", busy[1], wr_ready[1]);
    end
    pulse_stop(1);
    checks++;
    if (pwm_enable[1] !== 1'b0 || busy[1] !== 1'b0 || wr_ready[1] !== 1'b1 || t_on[1] !== 32'd35) begin
      errors++;
      $display("FAIL stop_pend en/busy/ready=%b%b%b on=%0d exp 001 on=35",
               pwm_enable[1], busy[1], wr_ready[1], t_on[1]);
    end
    pulse_period_end(1);
    checks++;
    if (t_on[1] !== 32'd35 || t_period[1] !== 32'd100 || pwm_enable[1] !== 1'b0) begin
      errors++;
      $display("FAIL stop_then_period_end vals=%0d/%0d en=%b exp 100/35 en=0",
               t_period[1], t_on[1], pwm_enable[1]);
    end
  endtask

  task automatic test_back_to_back();
    // Shadow on=90, period=100 from earlier: soft start toward 90.
    do_write(1, 2'd2, 32'd3);
    pulse_period_end(1);
    checks++;
    if (t_on[1] !== 32'd10 || busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL retarget_first_step on=%0d busy=%b exp on=10 busy=1", t_on[1], busy[1]);
    end
    do_write(1, 2'd1, 32'd15);
    // Commit and period_end on the same edge: step still heads for 90.
    wr_valid[1]   = 1'b1;
    wr_addr[1]    = 2'd2;
    wr_data[1]    = 32'd3;
    period_end[1] = 1'b1;
    tick();
    wr_valid[1]   = 1'b0;
    period_end[1] = 1'b0;
    checks++;
    if (t_on[1] !== 32'd20 || busy[1] !== 1'b1 || wr_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_step on=%0d busy/ready=%b%b exp on=20 10", t_on[1], busy[1], wr_ready[1]);
    end
    pulse_period_end(1);
    checks++;
    if (t_on[1] !== 32'd15 || busy[1] !== 1'b0 || wr_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL retarget_done on=%0d busy/ready=%b%b exp on=15 01", t_on[1], busy[1], wr_ready[1]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_valid[d]   = 1'b0;
      wr_addr[d]    = 2'd0;
      wr_data[d]    = 32'd0;
      stop[d]       = 1'b0;
      period_end[d] = 1'b0;
    end
    tick();
    tick();
    reset = 1'b1;
    tick();

    test_reset();
    test_enable_immediate();
    test_update_pending();
    test_clamp();
    test_commit_disabled();
    test_soft_start();
    test_stop_in_pend();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
